// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//   Writeback stage plus architectural register file. It picks the writeback
//   value from the MEM/WB outputs and commits it to x1..x31. It serves two
//   decode read ports, with write-through bypass in the same cycle. It also
//   keeps the retired-instruction counter and a registered commit record.
//
// Ports
//   clk, reset        clock (rising edge), async active-low reset
//   ALUResult_W       ALU result
//   r_Data_W          load data
//   PC_plus4_W        PC+4 of the W-stage instruction
//   instruction_W     instruction word, 0 marks a bubble
//   rd_W, regWrite_W  destination register and write enable
//   resultSrc_W       00 ALU, 01 load, 10 PC+4, 11 illegal
//   rs1_D, rs2_D      read addresses; rd1_D / rd2_D combinational read data
//   result_W          selected writeback value (combinational)
//   instret           retired-instruction count (wraps)
//   commit_valid/rd/data/pc   commit record, one cycle after the write edge
//   wb_illegal        pulse when an illegal result source is written
// ---------------------------------------------------------------------------
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  ALUResult_W,
    input  logic [XLEN-1:0]  r_Data_W,
    input  logic [XLEN-1:0]  PC_plus4_W,
    input  logic [31:0]      instruction_W,
    input  logic [4:0]       rd_W,
    input  logic             regWrite_W,
    input  logic [1:0]       resultSrc_W,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    output logic [XLEN-1:0]  rd1_D,
    output logic [XLEN-1:0]  rd2_D,
    output logic [XLEN-1:0]  result_W,
    output logic [CNT_W-1:0] instret,
    output logic             commit_valid,
    output logic [4:0]       commit_rd,
    output logic [XLEN-1:0]  commit_data,
    output logic [XLEN-1:0]  commit_pc,
    output logic             wb_illegal
);

    // x0 has no storage; reads of address 0 are forced to zero below.
    logic [XLEN-1:0] regs [1:NREGS-1];
    logic            we;
    logic            illegal_src;

    always_comb begin
        result_W = '0;
        case (resultSrc_W)
            2'b00:   result_W = ALUResult_W;
            2'b01:   result_W = r_Data_W;
            2'b10:   result_W = PC_plus4_W;
            default: result_W = '0;
        endcase
    end

    assign illegal_src = (resultSrc_W == 2'b11);
    assign we          = regWrite_W && (rd_W != 5'd0) && !illegal_src;

    // A read of the register being written this cycle returns the incoming
    // value, so decode never sees a stale operand.
    always_comb begin
        rd1_D = '0;
        if (rs1_D != 5'd0)
            rd1_D = (we && (rs1_D == rd_W)) ? result_W : regs[rs1_D];
    end

    always_comb begin
        rd2_D = '0;
        if (rs2_D != 5'd0)
            rd2_D = (we && (rs2_D == rd_W)) ? result_W : regs[rs2_D];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < NREGS; i++)
                regs[i] <= '0;
        end else if (we) begin
            regs[rd_W] <= result_W;
        end
    end

    // Every non-bubble instruction retires, including stores, branches and
    // illegal-source writebacks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret      <= '0;
            commit_valid <= 1'b0;
            commit_rd    <= '0;
            commit_data  <= '0;
            commit_pc    <= '0;
            wb_illegal   <= 1'b0;
        end else begin
            if (instruction_W != 32'd0)
                instret <= instret + CNT_W'(1);
            commit_valid <= we;
            wb_illegal   <= regWrite_W && illegal_src;
            if (we) begin
                commit_rd   <= rd_W;
                commit_data <= result_W;
                commit_pc   <= PC_plus4_W - XLEN'(4);
            end
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic [31:0] ALUResult_W, r_Data_W, PC_plus4_W, instruction_W;
    logic [4:0]  rd_W, rs1_D, rs2_D;
    logic        regWrite_W;
    logic [1:0]  resultSrc_W;
    logic [31:0] rd1_D, rd2_D, result_W, commit_data, commit_pc;
    logic [63:0] instret;
    logic        commit_valid, wb_illegal;
    logic [4:0]  commit_rd;

    wb_regfile dut (
        .clk(clk), .reset(reset),
        .ALUResult_W(ALUResult_W), .r_Data_W(r_Data_W), .PC_plus4_W(PC_plus4_W),
        .instruction_W(instruction_W), .rd_W(rd_W), .regWrite_W(regWrite_W),
        .resultSrc_W(resultSrc_W), .rs1_D(rs1_D), .rs2_D(rs2_D),
        .rd1_D(rd1_D), .rd2_D(rd2_D), .result_W(result_W), .instret(instret),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_data(commit_data), .commit_pc(commit_pc), .wb_illegal(wb_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state as plain arrays and variables.
    logic [31:0] m_regs [32];
    logic [63:0] m_cnt;
    logic [63:0] m_off = '0;
    logic        m_cv, m_ill;
    logic [4:0]  m_crd;
    logic [31:0] m_cdata, m_cpc;

    function automatic logic [31:0] m_result();
        case (resultSrc_W)
            2'b00:   return ALUResult_W;
            2'b01:   return r_Data_W;
            2'b10:   return PC_plus4_W;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_we();
        return regWrite_W && rd_W != 0 && resultSrc_W != 2'b11;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (m_we() && a == rd_W) return m_result();
        return m_regs[a];
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_cnt = '0; m_cv = 0; m_ill = 0; m_crd = '0; m_cdata = '0; m_cpc = '0;
        end else begin
            if (instruction_W != 0) m_cnt = m_cnt + 1;
            m_ill = regWrite_W && resultSrc_W == 2'b11;
            m_cv  = m_we();
            if (m_we()) begin
                m_crd   = rd_W;
                m_cdata = m_result();
                m_cpc   = PC_plus4_W - 32'd4;
                m_regs[rd_W] = m_result();
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("cyc_result_W", result_W, m_result());
            check("cyc_rd1_D", rd1_D, m_read(rs1_D));
            check("cyc_rd2_D", rd2_D, m_read(rs2_D));
            check("cyc_instret", instret, m_cnt + m_off);
            check("cyc_commit_valid", commit_valid, m_cv);
            check("cyc_commit_rd", commit_rd, m_crd);
            check("cyc_commit_data", commit_data, m_cdata);
            check("cyc_commit_pc", commit_pc, m_cpc);
            check("cyc_wb_illegal", wb_illegal, m_ill);
        end
    end

    task automatic drive(input logic rw, input logic [1:0] src, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc4,
                         input logic [31:0] ins, input logic [4:0] a1, input logic [4:0] a2);
        regWrite_W = rw; resultSrc_W = src; rd_W = rd;
        ALUResult_W = alu; r_Data_W = ld; PC_plus4_W = pc4;
        instruction_W = ins; rs1_D = a1; rs2_D = a2;
    endtask

    task automatic bubble(input logic [4:0] a1, input logic [4:0] a2);
        drive(0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, a1, a2);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        bubble(0, 0);
        tick();
        tick();
        reset = 1'b1;
        checking = 1'b1;
        #1;
        check("reset_instret", instret, 64'd0);
        check("reset_commit_valid", commit_valid, 0);

        // ALU write with bypass, then read from the array
        drive(1, 2'b00, 5'd5, 32'hDEADBEEF, 32'd0, 32'h200, 32'h13, 5'd5, 5'd0);
        #1;
        check("alu_bypass_rd1", rd1_D, 32'hDEADBEEF);
        tick();
        bubble(5, 0);
        #1;
        check("alu_array_rd1", rd1_D, 32'hDEADBEEF);
        check("alu_commit_valid", commit_valid, 1);
        check("alu_commit_rd", commit_rd, 5);
        check("alu_commit_data", commit_data, 32'hDEADBEEF);
        check("alu_commit_pc", commit_pc, 32'h1FC);

        // Load into x7, then JAL link into x1
        tick();
        drive(1, 2'b01, 5'd7, 32'd0, 32'h12345678, 32'hFC, 32'h03, 5'd7, 5'd0);
        tick();
        drive(1, 2'b10, 5'd1, 32'd0, 32'd0, 32'h104, 32'h6F, 5'd7, 5'd1);
        #1;
        check("jal_bypass_rd2", rd2_D, 32'h104);
        check("load_array_rd1", rd1_D, 32'h12345678);
        tick();
        bubble(7, 1);
        #1;
        check("jal_commit_pc", commit_pc, 32'h100);
        check("jal_commit_data", commit_data, 32'h104);
        check("x7_value", rd1_D, 32'h12345678);
        check("x1_value", rd2_D, 32'h104);

        // Write to x0 is dropped but still retires
        tick();
        drive(1, 2'b00, 5'd0, 32'hFFFFFFFF, 32'd0, 32'h300, 32'h13, 5'd0, 5'd0);
        #1;
        check("x0_rd1", rd1_D, 32'd0);
        check("x0_result", result_W, 32'hFFFFFFFF);
        tick();
        bubble(0, 0);
        #1;
        check("x0_no_commit", commit_valid, 0);
        check("x0_commit_rd_held", commit_rd, 1);
        check("x0_instret", instret, 64'd4);

        // Illegal result source
        tick();
        drive(1, 2'b11, 5'd3, 32'h55, 32'h66, 32'h400, 32'h13, 5'd3, 5'd0);
        #1;
        check("ill_result_zero", result_W, 32'd0);
        check("ill_no_bypass", rd1_D, 32'd0);
        tick();
        bubble(3, 0);
        #1;
        check("ill_pulse", wb_illegal, 1);
        check("ill_no_commit", commit_valid, 0);
        check("ill_x3_unchanged", rd1_D, 32'd0);
        check("ill_instret", instret, 64'd5);
        tick();
        check("ill_pulse_end", wb_illegal, 0);

        // Back-to-back writes to the same register
        drive(1, 2'b00, 5'd5, 32'd1, 32'd0, 32'h500, 32'h13, 5'd5, 5'd5);
        tick();
        drive(1, 2'b00, 5'd5, 32'd2, 32'd0, 32'h504, 32'h13, 5'd5, 5'd5);
        #1;
        check("b2b_bypass", rd1_D, 32'd2);
        tick();
        bubble(5, 5);
        #1;
        check("b2b_last_wins", rd2_D, 32'd2);
        check("b2b_instret", instret, 64'd7);

        // Asynchronous reset mid-run; write on the edge inside reset is dropped
        bubble(7, 1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_rd1", rd1_D, 32'd0);
        check("rst_rd2", rd2_D, 32'd0);
        check("rst_instret", instret, 64'd0);
        check("rst_commit_valid", commit_valid, 0);
        check("rst_commit_data", commit_data, 32'd0);
        drive(1, 2'b00, 5'd9, 32'hAA, 32'd0, 32'h600, 32'd0, 5'd0, 5'd0);
        tick();
        reset = 1'b1;
        bubble(9, 0);
        #1;
        check("rst_write_dropped", rd1_D, 32'd0);
        check("rst_commit_dropped", commit_valid, 0);

        // 10 instructions with 3 interleaved bubbles
        tick();
        for (int i = 0; i < 13; i++) begin
            drive(0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0,
                  (i == 2 || i == 6 || i == 10) ? 32'd0 : 32'h13, 5'd0, 5'd0);
            tick();
        end
        bubble(0, 0);
        #1;
        check("cnt_ten", instret, 64'd10);

        // Preload all-ones and retire one more: counter wraps to zero
        force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
        m_off = 64'hFFFF_FFFF_FFFF_FFFF - m_cnt;
        #1;
        release dut.instret;
        check("cnt_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0, 32'h13, 5'd0, 5'd0);
        tick();
        bubble(0, 0);
        #1;
        check("cnt_wrap", instret, 64'd0);
        tick();
        tick();

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
